// File: rtl/cpu32_pkg.sv
// Shared cpu32 datapath constants: default word/address widths and the
// index of the hardwired-zero register.
package cpu32_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/reg_word.sv
// One W-bit register with load enable and asynchronous active-high clear.
// Used both for register-file storage words and for the read-port outputs.
module reg_word #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile32.sv
// Two-read/one-write register file with registered read data, same-edge
// write-to-read forwarding and a hardwired-zero register 0.
module regfile32 #(
  parameter int DATA_W = cpu32_pkg::DATA_W,
  parameter int ADDR_W = cpu32_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              RE1,
  input  logic [ADDR_W-1:0] RADDR1,
  output logic [DATA_W-1:0] RDATA1,
  input  logic              RE2,
  input  logic [ADDR_W-1:0] RADDR2,
  output logic [DATA_W-1:0] RDATA2
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(cpu32_pkg::REG_ZERO);

  logic [DATA_W-1:0] word_q [DEPTH];
  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;

  // Word 0 has no storage; WADDR=0 never matches a storage word's decode.
  assign word_q[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_word
    reg_word #(.W(DATA_W)) u_word (
      .clk  (CLK),
      .rst  (RST),
      .load (WE && (WADDR == ADDR_W'(i))),
      .d    (WDATA),
      .q    (word_q[i])
    );
  end

  // Read value is the word as it stands after this edge's write.
  always_comb begin
    rd1_next = word_q[RADDR1];
    if (RADDR1 == ZERO_ADDR) begin
      rd1_next = '0;
    end else if (WE && (WADDR == RADDR1)) begin
      rd1_next = WDATA;
    end
  end

  always_comb begin
    rd2_next = word_q[RADDR2];
    if (RADDR2 == ZERO_ADDR) begin
      rd2_next = '0;
    end else if (WE && (WADDR == RADDR2)) begin
      rd2_next = WDATA;
    end
  end

  // REn qualifies the output register load: with REn=0 the port holds its
  // last value regardless of writes to the address it last read.
  reg_word #(.W(DATA_W)) u_rd1 (
    .clk  (CLK),
    .rst  (RST),
    .load (RE1),
    .d    (rd1_next),
    .q    (RDATA1)
  );

  reg_word #(.W(DATA_W)) u_rd2 (
    .clk  (CLK),
    .rst  (RST),
    .load (RE2),
    .d    (rd2_next),
    .q    (RDATA2)
  );

endmodule

// File: tb/tb_regfile32.sv
// Self-checking bench for regfile32: directed vector table, reset corner
// sequence, then randomized traffic against an array-based reference model.
module tb_regfile32;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 1 << AW;

  // ---------------- clock / reset ----------------
  logic          CLK = 1'b0;
  logic          RST;
  logic          WE;
  logic [AW-1:0] WADDR;
  logic [DW-1:0] WDATA;
  logic          RE1;
  logic [AW-1:0] RADDR1;
  logic [DW-1:0] RDATA1;
  logic          RE2;
  logic [AW-1:0] RADDR2;
  logic [DW-1:0] RDATA2;

  always #5 CLK = ~CLK;

  regfile32 #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .WE     (WE),
    .WADDR  (WADDR),
    .WDATA  (WDATA),
    .RE1    (RE1),
    .RADDR1 (RADDR1),
    .RDATA1 (RDATA1),
    .RE2    (RE2),
    .RADDR2 (RADDR2),
    .RDATA2 (RDATA2)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] model_mem [NREG];
  logic [DW-1:0] model_rd1;
  logic [DW-1:0] model_rd2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) model_mem[i] = '0;
    model_rd1 = '0;
    model_rd2 = '0;
  endtask

  // One clock edge of the architectural behaviour: write first, then reads
  // observe the updated array; register 0 reads zero.
  task automatic model_edge();
    if (RST) begin
      model_clear();
    end else begin
      if (WE && WADDR != 0) model_mem[WADDR] = WDATA;
      if (RE1) model_rd1 = (RADDR1 == 0) ? '0 : model_mem[RADDR1];
      if (RE2) model_rd2 = (RADDR2 == 0) ? '0 : model_mem[RADDR2];
    end
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  // Drive inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic re1, input logic [AW-1:0] a1,
                      input logic re2, input logic [AW-1:0] a2);
    WE = we; WADDR = wa; WDATA = wd;
    RE1 = re1; RADDR1 = a1; RE2 = re2; RADDR2 = a2;
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          re1;
    logic [AW-1:0] ra1;
    logic          re2;
    logic [AW-1:0] ra2;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  initial begin
    logic [AW-1:0] a1, a2, wa;

    vecs[0]  = '{1'b1, 5'd3,  32'h12345678, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd0,  32'h12345678, 32'h0};
    vecs[2]  = '{1'b1, 5'd7,  32'h00000001, 1'b0, 5'd0,  1'b0, 5'd0,  32'h12345678, 32'h0};
    vecs[3]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b1, 5'd7,  1'b1, 5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
    vecs[6]  = '{1'b1, 5'd9,  32'h00000055, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd0,  32'h00000055, 32'h0};
    vecs[8]  = '{1'b1, 5'd9,  32'h000000AA, 1'b0, 5'd9,  1'b0, 5'd9,  32'h00000055, 32'h0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd9,  1'b0, 5'd9,  32'h00000055, 32'h0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd0,  32'h000000AA, 32'h0};
    vecs[11] = '{1'b1, 5'd31, 32'h80000000, 1'b0, 5'd0,  1'b0, 5'd0,  32'h000000AA, 32'h0};
    vecs[12] = '{1'b1, 5'd1,  32'h00000001, 1'b0, 5'd0,  1'b0, 5'd0,  32'h000000AA, 32'h0};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd1,  32'h80000000, 32'h00000001};

    RST = 1'b1;
    WE = 1'b0; WADDR = '0; WDATA = '0;
    RE1 = 1'b0; RADDR1 = '0; RE2 = 1'b0; RADDR2 = '0;
    model_clear();

    #12;
    check("reset_rd1", RDATA1, '0);
    check("reset_rd2", RDATA2, '0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
           vecs[i].re1, vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
      check($sformatf("vec%0d_rd1", i), RDATA1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), RDATA2, vecs[i].exp2);
    end

    // Reset mid-operation: outputs clear before the next edge, a write
    // during reset is lost, storage reads back zero afterwards.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b1, 5'd5);
    check("pre_rst_rd1", RDATA1, 32'hDEADBEEF);
    check("pre_rst_rd2", RDATA2, 32'hDEADBEEF);
    #3;
    RST = 1'b1;
    #1;
    check("async_rst_rd1", RDATA1, '0);
    check("async_rst_rd2", RDATA2, '0);
    model_clear();
    step(1'b1, 5'd6, 32'hCAFEF00D, 1'b1, 5'd6, 1'b1, 5'd6);
    check("rst_held_rd1", RDATA1, '0);
    check("rst_held_rd2", RDATA2, '0);
    RST = 1'b0;
    step(1'b1, 5'd8, 32'h00001234, 1'b1, 5'd8, 1'b1, 5'd5);
    check("rst_release_fwd", RDATA1, 32'h00001234);
    check("rst_r5_cleared", RDATA2, '0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1, 5'd8);
    check("rst_write_lost", RDATA1, '0);
    check("post_rst_store", RDATA2, 32'h00001234);

    // Randomized traffic; narrow address window half the time to provoke
    // forwarding and same-address collisions.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        wa = AW'($urandom_range(0, 3));
        a1 = AW'($urandom_range(0, 3));
        a2 = AW'($urandom_range(0, 3));
      end else begin
        wa = AW'($urandom_range(0, NREG - 1));
        a1 = AW'($urandom_range(0, NREG - 1));
        a2 = AW'($urandom_range(0, NREG - 1));
      end
      step(1'($urandom_range(0, 1)), wa, $urandom,
           1'($urandom_range(0, 3) != 0), a1,
           1'($urandom_range(0, 3) != 0), a2);
      check("rand_rd1", RDATA1, model_rd1);
      check("rand_rd2", RDATA2, model_rd2);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
